// File: rtl/usb_gpx_pkg.sv
// usb_gpx_pkg
//   Shared constants for the GPX conditioner: Avalon word addresses of the
//   four registers and the bit positions of the rise/fall edge flags.
package usb_gpx_pkg;

  localparam logic [1:0] GPX_DATA   = 2'd0;
  localparam logic [1:0] GPX_MASK   = 2'd1;
  localparam logic [1:0] GPX_EDGE   = 2'd2;
  localparam logic [1:0] GPX_STATUS = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;

endpackage

// File: rtl/usb_gpx_deglitch.sv
// usb_gpx_deglitch
//   Two-flop synchronizer followed by a stability filter for the raw GPX pin.
//   The filtered level follows the synced input only after it has differed
//   from the current level for FILTER_CYCLES consecutive clocks.
// Ports
//   clk, reset   : system clock, async active-high reset
//   in_raw       : asynchronous GPX pin
//   level        : filtered level (registered)
//   raw_sync     : second synchronizer flop
//   busy         : filter counter is non-zero
//   rise_pulse   : high in the cycle before level goes 0->1
//   fall_pulse   : high in the cycle before level goes 1->0
module usb_gpx_deglitch #(
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 5,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic level,
  output logic raw_sync,
  output logic busy,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_update;

  assign w_differs = (r_s2 != r_level);
  // The counter already holds FILTER_CYCLES-1 matching-mismatch cycles, so this
  // one completes the window: total input-to-level latency is 2 + FILTER_CYCLES.
  assign w_update  = w_differs && (r_cnt == CNT_W'(FILTER_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= RESET_LEVEL;
      r_s2    <= RESET_LEVEL;
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_s1 <= in_raw;
      r_s2 <= r_s1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_update) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level      = r_level;
  assign raw_sync   = r_s2;
  assign busy       = (r_cnt != '0);
  // Pulses coincide with the edge that updates level, so capture logic
  // clocked on the same edge sees the change without extra delay.
  assign rise_pulse = w_update &&  r_s2;
  assign fall_pulse = w_update && !r_s2;

endmodule

// File: rtl/usb_gpx_conditioner.sv
// usb_gpx_conditioner
//   Conditions the MAX3421E GPX pin: synchronizer + glitch filter, sticky
//   edge capture, Avalon-MM register slave and a level interrupt.
// Ports
//   clk, reset            : system clock, async active-high reset
//   address[1:0]          : word address (DATA, MASK, EDGE, STATUS)
//   chipselect, write_n   : Avalon write qualifier (write = cs & ~write_n)
//   writedata[31:0]       : write data
//   readdata[31:0]        : registered read data, one cycle after address
//   in_port               : raw asynchronous GPX pin
//   level_out             : filtered GPX level
//   irq                   : active-high level interrupt
module usb_gpx_conditioner
  import usb_gpx_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 5,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        level_out,
  output logic        irq
);

  logic        w_level;
  logic        w_raw_sync;
  logic        w_busy;
  logic        w_rise;
  logic        w_fall;
  logic        w_wr;
  logic [1:0]  w_edge_set;
  logic [1:0]  w_edge_clr;
  logic [31:0] w_rd_mux;
  logic        w_unused_wdata;

  logic [1:0]  r_mask;
  logic [1:0]  r_edge_cap;
  logic        r_irq;
  logic [31:0] r_readdata;

  usb_gpx_deglitch #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .CNT_W         (CNT_W),
    .RESET_LEVEL   (RESET_LEVEL)
  ) u_deglitch (
    .clk        (clk),
    .reset      (reset),
    .in_raw     (in_port),
    .level      (w_level),
    .raw_sync   (w_raw_sync),
    .busy       (w_busy),
    .rise_pulse (w_rise),
    .fall_pulse (w_fall)
  );

  assign w_wr           = chipselect && !write_n;
  assign w_unused_wdata = ^writedata[31:2];

  always_comb begin
    w_edge_set            = '0;
    w_edge_set[EDGE_RISE] = w_rise;
    w_edge_set[EDGE_FALL] = w_fall;
  end

  assign w_edge_clr = (w_wr && address == GPX_EDGE) ? writedata[1:0] : 2'b00;

  always_comb begin
    w_rd_mux = '0;
    case (address)
      GPX_DATA:   w_rd_mux[0]   = w_level;
      GPX_MASK:   w_rd_mux[1:0] = r_mask;
      GPX_EDGE:   w_rd_mux[1:0] = r_edge_cap;
      GPX_STATUS: w_rd_mux[1:0] = {w_busy, w_raw_sync};
      default:    w_rd_mux      = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask     <= '0;
      r_edge_cap <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_wr && address == GPX_MASK) begin
        r_mask <= writedata[1:0];
      end
      // Set applied after clear so a same-cycle capture wins over W1C.
      r_edge_cap <= (r_edge_cap & ~w_edge_clr) | w_edge_set;
      r_irq      <= |(r_edge_cap & r_mask);
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata  = r_readdata;
  assign level_out = w_level;
  assign irq       = r_irq;

endmodule
